vga_stream_timing: RTL and testbench
====================================

VGA_STREAM_TIMING -- requirements
Module: vga_stream_timing

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line.
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch in lines.
- HS_POL / VS_POL, 0 / 0, active sync level; 0 means active-low.
- COLOR_W, 8, bits per colour channel.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, pixel clock.
- RST, in, 1, reset.
- enable, in, 1, run the timing counters.
- pix_valid, in, 1, input pixel valid.
- pix_ready, out, 1, FIFO can accept a pixel.
- pix_data, in, 3*COLOR_W, pixel colour as {r,g,b}.
- pix_sof, in, 1, marks the first pixel of a frame.
- vga_hsync, out, 1, horizontal sync.
- vga_vsync, out, 1, vertical sync.
- vga_blank, out, 1, high outside the active area.
- vga_red / vga_green / vga_blue, out, COLOR_W each, colour outputs.
- frame_start, out, 1, one-cycle pulse on the first active pixel output.
- underflow, out, 1, sticky underflow flag.
- underflow_clr, in, 1, clears underflow.

REQ-003 Single clock CLK; RST is synchronous, active-high.

Function
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h_cnt wraps from H_TOTAL-1 to 0; v_cnt increments on that wrap and wraps from V_TOTAL-1 to 0.

REQ-005 Region order SHALL be active, FP, sync, BP on both axes.
- Sync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for v_cnt.

REQ-006 All video outputs SHALL be registered with latency 1 from the counter state.
- Sync, blank, colour and frame_start stay mutually aligned.

REQ-007 Blanked pixels SHALL output colour 0.

REQ-008 FIFO handshake:
- pix_ready = not full.
- A transfer occurs when pix_valid and pix_ready are both high.
- Each entry stores {sof, data}.

REQ-009 FIFO pop rules:
- An active pixel with the FIFO non-empty and not in resync pops the head and displays it.
- A simultaneous push and pop when full is not possible, because ready is low when full.
- A simultaneous push and pop when empty is not a bypass: the pushed pixel is not displayed that cycle.

REQ-010 Underflow: an active pixel with the FIFO empty SHALL output black, set underflow and enter resync.

REQ-011 Resync:
- Every cycle, discard the FIFO head while its sof is 0.
- Once the head has sof=1, hold it until the next h_cnt=0, v_cnt=0, then leave resync.

REQ-012 Sof mismatches:
- A head with sof=1 reached outside pixel (0,0) while not in resync SHALL enter resync without being popped.
- A head with sof=0 at pixel (0,0) SHALL also enter resync; that pixel displays black.

REQ-013 Underflow flag:
- underflow_clr clears the flag.
- If a set condition and a clear occur in the same cycle, set wins.

REQ-014 enable=0:
- Counters are held at 0,0 and outputs are blank with syncs inactive.
- The FIFO still accepts pixels and resync draining continues.
- On the next enable=1 cycle, counting starts at (0,0).

REQ-015 frame_start SHALL pulse only on the output cycle of pixel (0,0) while enabled.

Reset
REQ-016 While RST is high:
- Counters are 0 and the FIFO is empty.
- resync = 1 and underflow = 0.
- vga_blank = 1 and colours = 0.
- vga_hsync = ~HS_POL and vga_vsync = ~VS_POL.
- frame_start = 0 and pix_ready = 0.

REQ-017 RST asserted mid-frame SHALL reach the reset state on the next edge and discard FIFO contents.
- pix_ready SHALL be 1 on the first cycle after RST deasserts.

Configuration
REQ-018 With VGA_TEST_PATTERN_EN defined:
- A 1-bit input test_pattern is added.
- When test_pattern=1, active pixels show 8 equal-width colour bars from h_cnt, bar index = h_cnt*8/H_ACTIVE, with colour bits {r,g,b} = index[2:0] and each channel full-scale or 0.
- In that mode the FIFO is not popped and no underflow is flagged.
- Without the macro, the port and the generator are absent.

Verification
REQ-019 The bench SHALL cover these directed scenarios, using H 4/1/2/1 and V 3/1/1/1 unless noted:
- Reset timing: RST, then enable=1 with no input. hsync is active (low) for output cycles 6-7 of each 8-cycle line; vsync is active on line 4 of the 6-line frame; underflow sets on the first active pixel.
- Ordered stream: stream 12 pixels 1..12 with sof on the first. Active outputs show 1..12 in raster order, frame_start pulses once and underflow stays 0.
- Backpressure: FIFO_DEPTH=4 with a stalled enable and pushes 1,2,3,4,5. pix_ready drops after 4 pushes, pixel 5 is held by the source, and the output order is 1..5.
- Resync: feed 3 pixels without sof, then a sof frame. The 3 are discarded, the sof frame displays from (0,0) of the next frame, and underflow_clr then clears the flag.
- Reset mid-line: assert RST mid-line. All outputs return to reset values on the next edge and the FIFO is empty.
- Test pattern: with VGA_TEST_PATTERN_EN and H_ACTIVE=8, test_pattern=1 gives active colours 000,00F,0F0,0FF,F00,F0F,FF0,FFF (per channel, F=full-scale) with no FIFO pops.

Source files
------------

// File: rtl/vga_stream_timing.sv
// vga_stream_timing: VGA raster timing generator that displays a pixel stream
// buffered in a small FIFO, with frame alignment (resync) on the sof marker
// and a sticky underflow flag.
// Optional feature: define VGA_TEST_PATTERN_EN to add a test_pattern input
// that replaces the stream with eight vertical colour bars.
module vga_stream_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 pix_sof,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_pattern,
`endif
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_blank,
  output logic [COLOR_W-1:0]   vga_red,
  output logic [COLOR_W-1:0]   vga_green,
  output logic [COLOR_W-1:0]   vga_blue,
  output logic                 frame_start,
  output logic                 underflow,
  input  logic                 underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int DW      = 3 * COLOR_W;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          resync;

  // Raster position decode
  logic h_act, v_act, h_sync_rg, v_sync_rg, at_origin, active;

  assign h_act     = int'(h_cnt) < H_ACTIVE;
  assign v_act     = int'(v_cnt) < V_ACTIVE;
  assign h_sync_rg = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                     (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign v_sync_rg = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                     (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = enable && h_act && v_act;

  // Pixel FIFO: entries are {sof, data}; one extra pointer bit tells full from empty
  logic [DW:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  logic [DW:0]   head;
  logic          head_sof;
  logic [DW-1:0] head_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pix_ready  = ~fifo_full & ~RST;
  assign push       = pix_valid & pix_ready;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_sof   = head[DW];
  assign head_data  = head[DW-1:0];

  // Colour-bar generator (present only with VGA_TEST_PATTERN_EN)
  logic          tp_on;
  logic [DW-1:0] bar_rgb;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  assign tp_on   = enable & test_pattern;
  assign bar_idx = 3'((int'(h_cnt) * 8) / H_ACTIVE);
  assign bar_rgb = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
`else
  assign tp_on   = 1'b0;
  assign bar_rgb = '0;
`endif

  // Pop / display / resync decision for the current raster position
  logic show, uf_set, resync_nxt;

  always_comb begin
    // NOTE: every signal gets a default first, so no branch leaves one unassigned and infers a latch.
    pop        = 1'b0;
    show       = 1'b0;
    uf_set     = 1'b0;
    resync_nxt = resync;
    if (resync) begin
      if (!fifo_empty) begin
        if (!head_sof) begin
          pop = 1'b1;                       // discard stale pixels until a frame start
        end else if (enable && at_origin && !tp_on) begin
          pop        = 1'b1;                // aligned: show the sof pixel at (0,0)
          show       = 1'b1;
          resync_nxt = 1'b0;
        end
      end
    end else if (active && !tp_on && !fifo_empty) begin
      if (head_sof != at_origin) begin
        resync_nxt = 1'b1;                  // stream and raster disagree on frame start
      end else begin
        pop  = 1'b1;
        show = 1'b1;
      end
    end
    if (active && !tp_on && fifo_empty) begin
      uf_set     = 1'b1;
      resync_nxt = 1'b1;
    end
  end

  // FIFO storage write
  // NOTE: the storage array is deliberately not reset; the pointers alone define its contents.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {pix_sof, pix_data};
  end

  // FIFO pointers
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Raster counters, resync state and sticky underflow flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      resync    <= 1'b1;
      underflow <= 1'b0;
    end else begin
      if (!enable) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      resync <= resync_nxt;
      if (uf_set)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

  // Registered video outputs, one cycle behind the counter state
  always_ff @(posedge CLK) begin
    if (RST) begin
      vga_hsync   <= ~HS_POL;
      vga_vsync   <= ~VS_POL;
      vga_blank   <= 1'b1;
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= (enable && h_sync_rg) ? HS_POL : ~HS_POL;
      vga_vsync   <= (enable && v_sync_rg) ? VS_POL : ~VS_POL;
      vga_blank   <= ~active;
      frame_start <= enable & at_origin;
      if (show)
        {vga_red, vga_green, vga_blue} <= head_data;
      else if (tp_on && active)
        {vga_red, vga_green, vga_blue} <= bar_rgb;
      else
        {vga_red, vga_green, vga_blue} <= '0;
    end
  end

endmodule

// File: tb/tb_vga_stream_timing.sv
// tb_vga_stream_timing: directed bench for vga_stream_timing using a small
// 8x6 raster (H 4/1/2/1, V 3/1/1/1) and a 4-entry FIFO.
module tb_vga_stream_timing;

  localparam int CW = 8;
  localparam int DW = 3 * CW;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, enable, pix_valid, pix_sof, underflow_clr;
  logic [DW-1:0] pix_data;
  logic          pix_ready, vga_hsync, vga_vsync, vga_blank, frame_start, underflow;
  logic [CW-1:0] vga_red, vga_green, vga_blue;

  int checks = 0;
  int errors = 0;

  logic [DW:0]   src_q[$];   // pending source pixels {sof, data}
  logic [DW-1:0] seen[$];    // colours seen on active output cycles
  int            fs_cnt;

  vga_stream_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic          tp_enable, tp_pattern, tp_valid, tp_sof, tp_ready;
  logic [DW-1:0] tp_data;
  logic          tp_hsync, tp_vsync, tp_blank, tp_fs, tp_underflow;
  logic [CW-1:0] tp_red, tp_green, tp_blue;

  vga_stream_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .FIFO_DEPTH(4)
  ) dut_tp (
    .CLK(CLK), .RST(RST), .enable(tp_enable),
    .pix_valid(tp_valid), .pix_ready(tp_ready), .pix_data(tp_data), .pix_sof(tp_sof),
    .test_pattern(tp_pattern),
    .vga_hsync(tp_hsync), .vga_vsync(tp_vsync), .vga_blank(tp_blank),
    .vga_red(tp_red), .vga_green(tp_green), .vga_blue(tp_blue),
    .frame_start(tp_fs), .underflow(tp_underflow), .underflow_clr(1'b0)
  );
`endif

  // One clock: present the source head, note whether it transfers, sample at edge+1
  task automatic tick();
    logic fire;
    if (src_q.size() > 0) begin
      pix_valid = 1'b1;
      {pix_sof, pix_data} = src_q[0];
    end else begin
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = '0;
    end
    #1;
    fire = pix_valid && pix_ready;
    @(posedge CLK);
    #1;
    if (fire) void'(src_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (!vga_blank) seen.push_back({vga_red, vga_green, vga_blue});
      if (frame_start) fs_cnt++;
    end
  endtask

  task automatic do_reset();
    RST           = 1'b1;
    enable        = 1'b0;
    underflow_clr = 1'b0;
    src_q.delete();
    tick();
    tick();
    RST = 1'b0;
    seen.delete();
    fs_cnt = 0;
  endtask

  task automatic push_frame(input int n);
    for (int i = 1; i <= n; i++) src_q.push_back({(i == 1), DW'(i)});
  endtask

  task automatic test_reset();
    logic [29:0] got, exp;
    RST    = 1'b1;
    enable = 1'b1;
    src_q.delete();
    src_q.push_back({1'b1, 24'h123456});
    tick();
    tick();
    got = {vga_hsync, vga_vsync, vga_blank, frame_start, underflow, pix_ready,
           vga_red, vga_green, vga_blue};
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
    src_q.delete();
    RST    = 1'b0;
    enable = 1'b0;
    tick();
    checks++;
    if ({pix_ready, vga_blank, underflow} !== 3'b110) begin
      errors++;
      $display("FAIL ready_after_reset got=%b exp=110", {pix_ready, vga_blank, underflow});
    end
  endtask

  task automatic test_timing();
    logic [27:0] got, exp;
    int h, v;
    do_reset();
    enable = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      tick();
      h   = (n - 1) % 8;
      v   = (n - 1) / 8;
      got = {vga_hsync, vga_vsync, vga_blank, frame_start, vga_red, vga_green, vga_blue};
      exp = {!(h == 5 || h == 6), !(v == 4), !(h < 4 && v < 3), (n == 1), 24'h0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL timing h=%0d v=%0d got=%h exp=%h", h, v, got, exp);
      end
      if (n == 1) begin
        checks++;
        if (underflow !== 1'b1) begin
          errors++;
          $display("FAIL underflow_first_pixel got=%b exp=1", underflow);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_ordered();
    do_reset();
    push_frame(12);
    run(6);
    enable = 1'b1;
    run(48);
    checks++;
    if (seen.size() != 12) begin
      errors++;
      $display("FAIL ordered_count got=%0d exp=12", seen.size());
    end
    for (int k = 0; k < 12 && k < seen.size(); k++) begin
      checks++;
      if (seen[k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL ordered_pixel k=%0d got=%h exp=%h", k, seen[k], DW'(k + 1));
      end
    end
    checks++;
    if (fs_cnt != 1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL ordered_flags frame_starts=%0d underflow=%b exp 1 and 0", fs_cnt, underflow);
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    push_frame(5);
    tick();
    tick();
    tick();
    checks++;
    if (pix_ready !== 1'b1 || src_q.size() != 2) begin
      errors++;
      $display("FAIL bp_three ready=%b pending=%0d exp 1 and 2", pix_ready, src_q.size());
    end
    tick();
    checks++;
    if (pix_ready !== 1'b0 || src_q.size() != 1) begin
      errors++;
      $display("FAIL bp_full ready=%b pending=%0d exp 0 and 1", pix_ready, src_q.size());
    end
    run(3);
    checks++;
    if (pix_ready !== 1'b0 || src_q.size() != 1) begin
      errors++;
      $display("FAIL bp_stalled ready=%b pending=%0d exp 0 and 1", pix_ready, src_q.size());
    end
    enable = 1'b1;
    run(48);
    checks++;
    if (seen.size() != 12 || src_q.size() != 0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_frame active=%0d pending=%0d underflow=%b exp 12 0 1",
               seen.size(), src_q.size(), underflow);
    end
    for (int k = 0; k < 12 && k < seen.size(); k++) begin
      checks++;
      if (seen[k] !== ((k < 5) ? DW'(k + 1) : DW'(0))) begin
        errors++;
        $display("FAIL bp_pixel k=%0d got=%h exp=%h", k, seen[k], (k < 5) ? DW'(k + 1) : DW'(0));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_resync();
    do_reset();
    for (int i = 1; i <= 3; i++) src_q.push_back({1'b0, 24'hAA0000 + DW'(i)});
    push_frame(12);
    enable = 1'b1;
    run(48);
    checks++;
    if (underflow !== 1'b1 || seen.size() != 12) begin
      errors++;
      $display("FAIL resync_frame1 underflow=%b active=%0d exp 1 and 12", underflow, seen.size());
    end
    for (int k = 0; k < 12 && k < seen.size(); k++) begin
      checks++;
      if (seen[k] !== DW'(0)) begin
        errors++;
        $display("FAIL resync_black k=%0d got=%h exp=0", k, seen[k]);
      end
    end
    run(31);
    underflow_clr = 1'b1;
    run(1);
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear got=%b exp=0", underflow);
    end
    checks++;
    if (seen.size() != 24 || fs_cnt != 2) begin
      errors++;
      $display("FAIL resync_counts active=%0d frame_starts=%0d exp 24 and 2", seen.size(), fs_cnt);
    end
    for (int k = 12; k < 24 && k < seen.size(); k++) begin
      checks++;
      if (seen[k] !== DW'(k - 11)) begin
        errors++;
        $display("FAIL resync_pixel k=%0d got=%h exp=%h", k, seen[k], DW'(k - 11));
      end
    end
    run(16);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_stays_clear got=%b exp=0", underflow);
    end
    underflow_clr = 1'b1;
    run(1);
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set_wins got=%b exp=1", underflow);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [29:0] got, exp;
    do_reset();
    push_frame(12);
    run(6);
    enable = 1'b1;
    run(2);
    checks++;
    if ({vga_blank, vga_red, vga_green, vga_blue} !== {1'b0, 24'h2}) begin
      errors++;
      $display("FAIL midline_pixel got=%h exp=%h", {vga_blank, vga_red, vga_green, vga_blue},
               {1'b0, 24'h2});
    end
    RST = 1'b1;
    src_q.delete();
    tick();
    got = {vga_hsync, vga_vsync, vga_blank, frame_start, underflow, pix_ready,
           vga_red, vga_green, vga_blue};
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midline_reset got=%h exp=%h", got, exp);
    end
    RST = 1'b0;
    tick();
    // Empty FIFO and counters at (0,0): first pixel is black, underflows, pulses frame_start
    got = {vga_hsync, vga_vsync, vga_blank, frame_start, underflow, pix_ready,
           vga_red, vga_green, vga_blue};
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL after_midline_reset got=%h exp=%h", got, exp);
    end
    enable = 1'b0;
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [24:0] got, exp;
    logic [3:0]  hb;
    int h, v;
    tp_enable  = 1'b0;
    tp_pattern = 1'b0;
    tp_valid   = 1'b0;
    tp_sof     = 1'b0;
    tp_data    = '0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tp_valid = 1'b1;
      tp_sof   = (i == 1);
      tp_data  = DW'(i);
      tick();
    end
    tp_valid = 1'b0;
    checks++;
    if (tp_ready !== 1'b0) begin
      errors++;
      $display("FAIL tp_prefill ready=%b exp=0", tp_ready);
    end
    tp_enable  = 1'b1;
    tp_pattern = 1'b1;
    for (int n = 1; n <= 72; n++) begin
      tick();
      h   = (n - 1) % 12;
      v   = (n - 1) / 12;
      hb  = 4'(h);
      got = {tp_blank, tp_red, tp_green, tp_blue};
      if (h < 8 && v < 3)
        exp = {1'b0, {CW{hb[2]}}, {CW{hb[1]}}, {CW{hb[0]}}};
      else
        exp = {1'b1, 24'h0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL tp_bar h=%0d v=%0d got=%h exp=%h", h, v, got, exp);
      end
    end
    checks++;
    if (tp_underflow !== 1'b0 || tp_ready !== 1'b0) begin
      errors++;
      $display("FAIL tp_no_pop underflow=%b ready=%b exp 0 and 0", tp_underflow, tp_ready);
    end
    tp_pattern = 1'b0;
    tick();
    checks++;
    if ({tp_blank, tp_red, tp_green, tp_blue} !== {1'b0, 24'h1}) begin
      errors++;
      $display("FAIL tp_stream_resume got=%h exp=%h", {tp_blank, tp_red, tp_green, tp_blue},
               {1'b0, 24'h1});
    end
    tp_enable = 1'b0;
  endtask
`endif

  initial begin
    RST           = 1'b1;
    enable        = 1'b0;
    underflow_clr = 1'b0;
    pix_valid     = 1'b0;
    pix_sof       = 1'b0;
    pix_data      = '0;
    fs_cnt        = 0;
`ifdef VGA_TEST_PATTERN_EN
    tp_enable  = 1'b0;
    tp_pattern = 1'b0;
    tp_valid   = 1'b0;
    tp_sof     = 1'b0;
    tp_data    = '0;
`endif
    test_reset();
    test_timing();
    test_ordered();
    test_backpressure();
    test_resync();
    test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
